// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared widths, opcodes, flag indices and controller states
//               for the time-shared ALU controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int FLAG_W = 4;
    localparam int OP_W   = 4;

    // Flag bus is {C,Z,N,V}
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_INC   = 4'd8,
        OP_DEC   = 4'd9,
        OP_PASSA = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick; search starts one past
//               the pointer and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] pointer,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        grant   = '0;
        index   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(pointer) + k) % N);
            if (enable && !w_found && req[w_cand]) begin
                w_found       = 1'b1;
                grant[w_cand] = 1'b1;
                index         = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Round-robin time-sharing of one fixed-latency ALU between
//               NREQ requesters, one operation in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int ALU_LAT = 2,
    parameter  int CNT_W   = 16,
    localparam int GID_W   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*OP_W-1:0]   req_op,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]      rsp_result,
    output logic [FLAG_W-1:0]      rsp_flags,
    output logic                   alu_start,
    output logic [OP_W-1:0]        alu_op,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic [FLAG_W-1:0]      alu_flags,
    output logic                   busy,
    output logic [GID_W-1:0]       grant_id,
    output logic [CNT_W-1:0]       op_count
);

    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    ctrl_state_e       r_state;
    ctrl_state_e       w_state_next;
    logic [GID_W-1:0]  r_last_grant;
    logic [GID_W-1:0]  w_win_idx;
    logic [NREQ-1:0]   w_win_grant;
    logic              w_win_any;
    logic              w_arb_en;
    logic              w_rsp_hs;
    logic [LAT_W-1:0]  r_lat_cnt;

    logic [OP_W-1:0]   w_op_arr [NREQ];
    logic [DATA_W-1:0] w_a_arr  [NREQ];
    logic [DATA_W-1:0] w_b_arr  [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_op_arr[gi] = req_op[gi*OP_W +: OP_W];
        assign w_a_arr[gi]  = req_a[gi*DATA_W +: DATA_W];
        assign w_b_arr[gi]  = req_b[gi*DATA_W +: DATA_W];
    end

    // Gating with rst keeps req_ready low while reset is held
    assign w_arb_en  = (r_state == IDLE) && !rst;
    assign w_win_any = |w_win_grant;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req     (req_valid),
        .pointer (r_last_grant),
        .enable  (w_arb_en),
        .grant   (w_win_grant),
        .index   (w_win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        rsp_valid    = '0;
        alu_start    = 1'b0;
        busy         = 1'b1;
        w_rsp_hs     = 1'b0;
        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = w_win_grant;
                if (w_win_any) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                alu_start    = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = NREQ'(1) << grant_id;
                if (rsp_ready[grant_id]) begin
                    w_rsp_hs     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GID_W'(NREQ - 1);
            grant_id     <= '0;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            r_lat_cnt    <= '0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            op_count     <= '0;
        end else begin
            if ((r_state == IDLE) && w_win_any) begin
                alu_op       <= w_op_arr[w_win_idx];
                alu_a        <= w_a_arr[w_win_idx];
                alu_b        <= w_b_arr[w_win_idx];
                grant_id     <= w_win_idx;
                r_last_grant <= w_win_idx;
            end

            // Counter reaches zero in the cycle the ALU output is valid
            if (r_state == ISSUE) begin
                r_lat_cnt <= LAT_W'(ALU_LAT - 1);
            end else if ((r_state == WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end

            if ((r_state == WAIT) && (r_lat_cnt == '0)) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
            end

            if (w_rsp_hs) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_share_ctrl
// Description : Randomized bench with a transaction-level reference model
//               and a behavioural fixed-latency ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    localparam int NREQ    = 4;
    localparam int ALU_LAT = 2;
    localparam int CNT_W   = 4;
    localparam int GID_W   = $clog2(NREQ);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*OP_W-1:0]   req_op;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]      rsp_result;
    logic [FLAG_W-1:0]      rsp_flags;
    logic                   alu_start;
    logic [OP_W-1:0]        alu_op;
    logic [DATA_W-1:0]      alu_a;
    logic [DATA_W-1:0]      alu_b;
    logic [DATA_W-1:0]      alu_result;
    logic [FLAG_W-1:0]      alu_flags;
    logic                   busy;
    logic [GID_W-1:0]       grant_id;
    logic [CNT_W-1:0]       op_count;

    alu_share_ctrl #(
        .NREQ    (NREQ),
        .ALU_LAT (ALU_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .busy       (busy),
        .grant_id   (grant_id),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {C,Z,N,V,result}
    function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD:   begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                            v = (a[7] == b[7]) && (r[7] != a[7]); end
            OP_SUB:   begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOT:   r = ~a;
            OP_SHL:   begin r = {a[6:0], 1'b0}; c = a[7]; end
            OP_SHR:   begin r = {1'b0, a[7:1]}; c = a[0]; end
            OP_INC:   begin r = a + 8'd1; c = (a == 8'hFF); v = (a == 8'h7F); end
            OP_DEC:   begin r = a - 8'd1; c = (a == 8'h00); v = (a == 8'h80); end
            OP_PASSA: r = a;
            default:  r = a ^ b ^ 8'h5A;
        endcase
        return {c, (r == 8'h00), r[7], v, r};
    endfunction

    // Behavioural ALU: output valid exactly ALU_LAT cycles after start, garbage otherwise
    logic [11:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_start ? alu_fn(alu_op, alu_a, alu_b) : 12'($urandom);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign {alu_flags, alu_result} = alu_pipe[ALU_LAT-1];

    // Reference model: accepted transactions, rotation pointer, completion count
    typedef struct {
        int         idx;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         t_acc;
    } txn_t;

    txn_t            q[$];
    txn_t            m_t;
    int              cyc   = 0;
    int              mptr  = NREQ - 1;
    int              mcnt  = 0;
    int              m_w;
    int              m_age;
    logic [NREQ-1:0] m_ready;
    logic [NREQ-1:0] m_rsp;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            mptr = NREQ - 1;
            mcnt = 0;
        end else begin
            chk("op_count", op_count, mcnt % (1 << CNT_W));
            m_ready = '0;
            m_w     = -1;
            if (q.size() == 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (m_w < 0 && req_valid[(mptr + k) % NREQ]) m_w = (mptr + k) % NREQ;
                end
                if (m_w >= 0) m_ready[m_w] = 1'b1;
            end
            chk("req_ready", req_ready, m_ready);
            chk("busy", busy, q.size() != 0);
            if (q.size() != 0) begin
                m_t   = q[0];
                m_age = cyc - m_t.t_acc;
                chk("alu_start", alu_start, m_age == 1);
                chk("grant_id", grant_id, m_t.idx);
                chk("alu_opab", {alu_op, alu_a, alu_b}, {m_t.op, m_t.a, m_t.b});
                m_rsp = (m_age >= ALU_LAT + 2) ? (NREQ'(1) << m_t.idx) : '0;
                chk("rsp_valid", rsp_valid, m_rsp);
                if (m_rsp != '0) begin
                    chk("rsp_data", {rsp_flags, rsp_result}, alu_fn(m_t.op, m_t.a, m_t.b));
                    if (rsp_ready[m_t.idx]) begin
                        void'(q.pop_front());
                        mcnt++;
                    end
                end
            end else begin
                chk("alu_start_idle", alu_start, 1'b0);
                chk("rsp_valid_idle", rsp_valid, '0);
            end
            if (m_w >= 0) begin
                q.push_back('{idx: m_w, op: req_op[m_w*OP_W +: OP_W],
                              a: req_a[m_w*DATA_W +: DATA_W], b: req_b[m_w*DATA_W +: DATA_W],
                              t_acc: cyc});
                mptr = m_w;
            end
        end
    end

    task automatic drive_req(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[i*OP_W +: OP_W]     = op;
        req_a[i*DATA_W +: DATA_W]  = a;
        req_b[i*DATA_W +: DATA_W]  = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) drive_req(i, 4'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        if (busy) chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 50);
        if (!req_ready[i]) chk("accept_timeout", req_ready, NREQ'(1) << i);
    endtask

    task automatic wait_rsp(input int i, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[i] && n < 50);
        if (!rsp_valid[i]) chk("rsp_timeout", rsp_valid, NREQ'(1) << i);
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          ng;
        int          last_acc;
        logic [11:0] exp_d;

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {req_ready, rsp_valid, alu_start, busy, grant_id, op_count,
                              alu_op, alu_a, alu_b, rsp_result, rsp_flags}, '0);
        rst = 1'b0;

        // Single ADD from requester 0
        @(posedge clk); #1;
        drive_req(0, OP_ADD, 8'h0F, 8'h01);
        req_valid = 4'b0001;
        #1;
        chk("p1_ready", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(0, n);
        chk("p1_latency", n, ALU_LAT + 2);
        chk("p1_result", rsp_result, 8'h10);
        chk("p1_flags", rsp_flags, 4'b0000);
        @(posedge clk); #1;
        chk("p1_count", op_count, 1);

        // All requesters valid, rotation continues past requester 0
        wait_idle();
        @(posedge clk); #1;
        rand_ops();
        req_valid = '1;
        ng = 0;
        last_acc = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                chk("rr_order", oh2i(req_ready), (1 + ng) % NREQ);
                if (ng > 0) chk("rr_spacing", c - last_acc, ALU_LAT + 3);
                last_acc = c;
                ng++;
            end
            @(posedge clk); #1;
            rand_ops();
        end
        chk("rr_grants", ng, 5);
        req_valid = '0;

        // Requester 2 stalls its response for 10 cycles
        wait_idle();
        @(posedge clk); #1;
        drive_req(2, OP_XOR, 8'hA5, 8'h3C);
        req_valid = 4'b0100;
        rsp_ready = 4'b1011;
        wait_ready(2);
        @(posedge clk); #1;
        req_valid = 4'b1011;
        wait_rsp(2, n);
        exp_d = alu_fn(OP_XOR, 8'hA5, 8'h3C);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", rsp_valid, 4'b0100);
            chk("stall_data", {rsp_flags, rsp_result}, exp_d);
            chk("stall_ready", req_ready, '0);
            chk("stall_busy", busy, 1'b1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = '1;

        // SUB borrow case delivered to requester 1 only
        wait_idle();
        @(posedge clk); #1;
        drive_req(1, OP_SUB, 8'h00, 8'h01);
        req_valid = 4'b0010;
        rsp_ready = 4'($urandom) | 4'b0010;
        wait_ready(1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(1, n);
        chk("sub_owner", rsp_valid, 4'b0010);
        chk("sub_result", rsp_result, 8'hFF);
        chk("sub_flags", rsp_flags, 4'b1010);
        @(posedge clk); #1;
        rsp_ready = '1;

        // Random traffic; op_count wraps several times
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            req_valid = 4'($urandom);
            rand_ops();
            for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = '1;

        // Asynchronous reset during WAIT
        wait_idle();
        @(posedge clk); #1;
        drive_req(3, OP_INC, 8'h7F, 8'h00);
        req_valid = 4'b1000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!alu_start && n < 50);
        chk("p6_start", alu_start, 1'b1);
        req_valid = '0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {req_ready, rsp_valid, alu_start, busy, grant_id, op_count,
                            alu_op, alu_a, alu_b, rsp_result, rsp_flags}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_rsp", rsp_valid, '0);
        end
        @(posedge clk); #1;
        rand_ops();
        req_valid = '1;
        #1;
        chk("post_rst_first", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
